// File: rtl/mem_access_unit.sv
// Load/store front end for a ready/valid BRAM: converts byte-addressed CPU accesses into
// word transactions with byte enables, splitting word-crossing accesses in two.
module mem_access_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_write,
  input  logic [31:0]           i_req_addr,
  input  logic [1:0]            i_req_size,
  input  logic                  i_req_unsigned,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_resp_valid,
  output logic [DATA_WIDTH-1:0] o_resp_rdata,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic [3:0]            o_mem_be,
  output logic                  o_mem_wr_valid,
  input  logic                  i_mem_wr_ready,
  output logic                  o_mem_rd_ready,
  input  logic                  i_mem_rd_valid,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  typedef enum logic [2:0] {StIdle, StWr0, StWr1, StRd0, StRd1, StResp} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              off_q, off_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic                    cross_q, cross_d;
  logic [7:0]              lane_be_q, lane_be_d;
  logic [ADDR_WIDTH-1:0]   idx0_q, idx0_d;
  logic [ADDR_WIDTH-1:0]   idx1_q, idx1_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   word0_q, word0_d;
  logic [DATA_WIDTH-1:0]   word1_q, word1_d;

  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]              mem_be_q, mem_be_d;
  logic                    mem_wr_valid_q, mem_wr_valid_d;
  logic                    mem_rd_ready_q, mem_rd_ready_d;
  logic                    resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;

  logic [1:0]              req_off;
  logic [3:0]              req_mask;
  logic [2:0]              req_bytes;
  logic [2*DATA_WIDTH-1:0] req_rot;
  logic [2*DATA_WIDTH-1:0] ld_pair;
  logic [DATA_WIDTH-1:0]   ld_shift;
  logic [DATA_WIDTH-1:0]   ld_ext;
  logic                    unused_bits;

  assign unused_bits = ^{i_req_addr[31:ADDR_WIDTH+2], req_rot[DATA_WIDTH-1:0],
                         ld_pair[2*DATA_WIDTH-1:DATA_WIDTH]};

  // Request decode, only consumed on the accepting cycle.
  always_comb begin
    req_off = i_req_addr[1:0];
    case (i_req_size)
      2'b00: begin
        req_mask  = 4'b0001;
        req_bytes = 3'd1;
      end
      2'b01: begin
        req_mask  = 4'b0011;
        req_bytes = 3'd2;
      end
      default: begin
        req_mask  = 4'b1111;
        req_bytes = 3'd4;
      end
    endcase
    // Upper half of the doubled word is the rotate-left by 8*off.
    req_rot = {i_req_wdata, i_req_wdata} << {req_off, 3'b000};
  end

  always_comb begin
    state_d   = state_q;
    off_d     = off_q;
    size_d    = size_q;
    uns_d     = uns_q;
    cross_d   = cross_q;
    lane_be_d = lane_be_q;
    idx0_d    = idx0_q;
    idx1_d    = idx1_q;
    wdata_d   = wdata_q;
    word0_d   = word0_q;
    word1_d   = word1_q;
    case (state_q)
      StIdle: begin
        if (i_req_valid) begin
          off_d     = req_off;
          size_d    = (i_req_size == 2'b11) ? 2'b10 : i_req_size;
          uns_d     = i_req_unsigned;
          lane_be_d = {4'b0000, req_mask} << req_off;
          cross_d   = (({1'b0, req_off} + req_bytes) > 3'd4);
          idx0_d    = i_req_addr[ADDR_WIDTH+1:2];
          idx1_d    = i_req_addr[ADDR_WIDTH+1:2] + ADDR_WIDTH'(1);
          wdata_d   = req_rot[2*DATA_WIDTH-1:DATA_WIDTH];
          word0_d   = '0;
          word1_d   = '0;
          state_d   = i_req_write ? StWr0 : StRd0;
        end
      end
      StWr0: begin
        if (i_mem_wr_ready) state_d = cross_q ? StWr1 : StResp;
      end
      StWr1: begin
        if (i_mem_wr_ready) state_d = StResp;
      end
      StRd0: begin
        if (i_mem_rd_valid) begin
          word0_d = i_mem_rdata;
          state_d = cross_q ? StRd1 : StResp;
        end
      end
      StRd1: begin
        if (i_mem_rd_valid) begin
          word1_d = i_mem_rdata;
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Load realignment and extension from the next-state word pair.
  always_comb begin
    ld_pair  = {word1_d, word0_d} >> {off_d, 3'b000};
    ld_shift = ld_pair[DATA_WIDTH-1:0];
    case (size_d)
      2'b00:   ld_ext = uns_d ? {24'b0, ld_shift[7:0]} : {{24{ld_shift[7]}}, ld_shift[7:0]};
      2'b01:   ld_ext = uns_d ? {16'b0, ld_shift[15:0]} : {{16{ld_shift[15]}}, ld_shift[15:0]};
      default: ld_ext = ld_shift;
    endcase
  end

  // Outputs are registered: decode them from the state being entered.
  always_comb begin
    mem_addr_d     = '0;
    mem_wdata_d    = '0;
    mem_be_d       = '0;
    mem_wr_valid_d = 1'b0;
    mem_rd_ready_d = 1'b0;
    resp_valid_d   = 1'b0;
    resp_rdata_d   = '0;
    case (state_d)
      StWr0: begin
        mem_addr_d     = idx0_d;
        mem_wdata_d    = wdata_d;
        mem_be_d       = lane_be_d[3:0];
        mem_wr_valid_d = 1'b1;
      end
      StWr1: begin
        mem_addr_d     = idx1_d;
        mem_wdata_d    = wdata_d;
        mem_be_d       = lane_be_d[7:4];
        mem_wr_valid_d = 1'b1;
      end
      StRd0: begin
        mem_addr_d     = idx0_d;
        mem_rd_ready_d = 1'b1;
      end
      StRd1: begin
        mem_addr_d     = idx1_d;
        mem_rd_ready_d = 1'b1;
      end
      StResp: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = ld_ext;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= StIdle;
      off_q          <= '0;
      size_q         <= '0;
      uns_q          <= 1'b0;
      cross_q        <= 1'b0;
      lane_be_q      <= '0;
      idx0_q         <= '0;
      idx1_q         <= '0;
      wdata_q        <= '0;
      word0_q        <= '0;
      word1_q        <= '0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_be_q       <= '0;
      mem_wr_valid_q <= 1'b0;
      mem_rd_ready_q <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      off_q          <= off_d;
      size_q         <= size_d;
      uns_q          <= uns_d;
      cross_q        <= cross_d;
      lane_be_q      <= lane_be_d;
      idx0_q         <= idx0_d;
      idx1_q         <= idx1_d;
      wdata_q        <= wdata_d;
      word0_q        <= word0_d;
      word1_q        <= word1_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_be_q       <= mem_be_d;
      mem_wr_valid_q <= mem_wr_valid_d;
      mem_rd_ready_q <= mem_rd_ready_d;
      resp_valid_q   <= resp_valid_d;
      resp_rdata_q   <= resp_rdata_d;
    end
  end

  assign o_req_ready    = (state_q == StIdle) && !i_rst;
  assign o_resp_valid   = resp_valid_q;
  assign o_resp_rdata   = resp_rdata_q;
  assign o_mem_addr     = mem_addr_q;
  assign o_mem_wdata    = mem_wdata_q;
  assign o_mem_be       = mem_be_q;
  assign o_mem_wr_valid = mem_wr_valid_q;
  assign o_mem_rd_ready = mem_rd_ready_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array reference memory, a ready/valid BRAM model and a
// per-cycle response/idle monitor, with directed cases followed by randomized traffic.
module tb_mem_access_unit;
  localparam int unsigned AW = 10;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_req_valid = 1'b0;
  logic          o_req_ready;
  logic          i_req_write = 1'b0;
  logic [31:0]   i_req_addr = '0;
  logic [1:0]    i_req_size = '0;
  logic          i_req_unsigned = 1'b0;
  logic [31:0]   i_req_wdata = '0;
  logic          o_resp_valid;
  logic [31:0]   o_resp_rdata;
  logic [AW-1:0] o_mem_addr;
  logic [31:0]   o_mem_wdata;
  logic [3:0]    o_mem_be;
  logic          o_mem_wr_valid;
  logic          o_mem_rd_ready;
  logic          wr_rdy = 1'b1;
  logic          rd_vld = 1'b0;
  logic [31:0]   rd_data = '0;
  logic          stall = 1'b0;

  mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_write(i_req_write), .i_req_addr(i_req_addr), .i_req_size(i_req_size),
    .i_req_unsigned(i_req_unsigned), .i_req_wdata(i_req_wdata),
    .o_resp_valid(o_resp_valid), .o_resp_rdata(o_resp_rdata),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
    .o_mem_wr_valid(o_mem_wr_valid), .i_mem_wr_ready(wr_rdy),
    .o_mem_rd_ready(o_mem_rd_ready), .i_mem_rd_valid(rd_vld), .i_mem_rdata(rd_data)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [31:0]   data;
  } wr_t;

  logic [7:0]    ref_mem [4096];
  logic [31:0]   bram [1024];
  wr_t           wr_log[$];
  logic [AW-1:0] rd_log[$];
  logic [31:0]   exp_q[$];
  int            lat_q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            acc_cyc = 0;
  int            resp_cnt = 0;
  logic [31:0]   last_rdata = '0;
  logic [31:0]   mon_e;
  int            mon_l;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // BRAM: write accepted when ready; read data one cycle after an unanswered rd_ready.
  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    wr_rdy <= stall ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (o_mem_wr_valid && wr_rdy) begin
      bram[o_mem_addr] <= merge(bram[o_mem_addr], o_mem_wdata, o_mem_be);
      wr_log.push_back({o_mem_addr, o_mem_be, o_mem_wdata});
    end
    if (o_mem_rd_ready && !rd_vld && (!stall || $urandom_range(0, 1) == 1)) begin
      rd_vld  <= 1'b1;
      rd_data <= bram[o_mem_addr];
      rd_log.push_back(o_mem_addr);
    end else begin
      rd_vld  <= 1'b0;
      rd_data <= $urandom;
    end
  end

  // Per-cycle compare against the expected-response queue.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_req_ready && i_req_valid) acc_cyc = cyc + 1;
      checks++;
      if (o_resp_valid) begin
        resp_cnt++;
        last_rdata = o_resp_rdata;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected actual=%h required=no response", o_resp_rdata);
        end else begin
          mon_e = exp_q.pop_front();
          mon_l = lat_q.pop_front();
          if (o_resp_rdata !== mon_e) begin
            errors++;
            $display("FAIL resp_rdata actual=%h required=%h", o_resp_rdata, mon_e);
          end
          if (mon_l >= 0) begin
            checks++;
            if (cyc + 1 - acc_cyc != mon_l) begin
              errors++;
              $display("FAIL latency actual=%0d required=%0d", cyc + 1 - acc_cyc, mon_l);
            end
          end
        end
      end else if (o_resp_rdata !== 32'h0) begin
        errors++;
        $display("FAIL rdata_idle actual=%h required=0", o_resp_rdata);
      end
      if (o_req_ready) begin
        checks++;
        if ({o_mem_addr, o_mem_wdata, o_mem_be, o_mem_wr_valid, o_mem_rd_ready} !== '0) begin
          errors++;
          $display("FAIL idle_mem actual=%h required=0",
                   {o_mem_addr, o_mem_wdata, o_mem_be, o_mem_wr_valid, o_mem_rd_ready});
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] size,
                                             input logic uns);
    logic [31:0] v;
    logic [11:0] ba;
    int          n;
    n = nbytes(size);
    v = '0;
    for (int k = 0; k < n; k++) begin
      ba = a[11:0] + 12'(k);
      v  = v | (32'(ref_mem[ba]) << (8 * k));
    end
    if (n < 4 && !uns && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [1:0] size, input logic [31:0] wd);
    logic [11:0] ba;
    for (int k = 0; k < nbytes(size); k++) begin
      ba = a[11:0] + 12'(k);
      ref_mem[ba] = wd[8*k +: 8];
    end
  endtask

  task automatic launch(input logic wr, input logic [31:0] a, input logic [1:0] size,
                        input logic uns, input logic [31:0] wd);
    int g;
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b1;
    i_req_write = wr;
    i_req_addr = a;
    i_req_size = size;
    i_req_unsigned = uns;
    i_req_wdata = wd;
    @(negedge i_clk);
    g = 0;
    while (!o_req_ready && g < 100) begin
      @(negedge i_clk);
      g++;
    end
    chk("accept_timeout", 32'(o_req_ready), 32'h1);
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    i_req_write = 1'($urandom_range(0, 1));
    i_req_addr = $urandom;
    i_req_size = 2'($urandom_range(0, 3));
    i_req_unsigned = 1'($urandom_range(0, 1));
    i_req_wdata = $urandom;
  endtask

  task automatic do_req(input logic wr, input logic [31:0] a, input logic [1:0] size,
                        input logic uns, input logic [31:0] wd, input int lat);
    int start;
    int g;
    if (wr) begin
      exp_q.push_back(32'h0);
      model_store(a, size, wd);
    end else begin
      exp_q.push_back(model_load(a, size, uns));
    end
    lat_q.push_back(lat);
    start = resp_cnt;
    launch(wr, a, size, uns, wd);
    g = 0;
    while (resp_cnt == start && g < 200) begin
      @(negedge i_clk);
      g++;
    end
    chk("resp_timeout", 32'(resp_cnt != start), 32'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int g;
    int mism;
    for (int i = 0; i < 4096; i++) begin
      ref_mem[i] = 8'($urandom);
      bram[i/4][8*(i%4) +: 8] = ref_mem[i];
    end
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_ready", 32'(o_req_ready), 32'h0);
    chk("rst_outs", 32'({o_resp_valid, o_mem_wr_valid, o_mem_rd_ready, o_mem_be}), 32'h0);
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    chk("ready_after_init", 32'(o_req_ready), 32'h1);

    wr_log.delete();
    do_req(1'b1, 32'h100, 2'b10, 1'b0, 32'h11223344, 2);
    chk("sw_cnt", 32'(wr_log.size()), 32'h1);
    chk("sw_addr", 32'(wr_log[0].addr), 32'd64);
    chk("sw_be", 32'(wr_log[0].be), 32'hF);
    chk("sw_data", wr_log[0].data, 32'h11223344);
    do_req(1'b0, 32'h100, 2'b10, 1'b0, 32'h0, 3);
    chk("lw_lit", last_rdata, 32'h11223344);

    wr_log.delete();
    do_req(1'b1, 32'h102, 2'b00, 1'b0, 32'h00000031, 2);
    chk("sb_be", 32'(wr_log[0].be), 32'h4);
    chk("sb_lane", 32'(wr_log[0].data[23:16]), 32'h31);
    do_req(1'b0, 32'h102, 2'b00, 1'b1, 32'h0, 3);
    chk("lbu_lit", last_rdata, 32'h00000031);
    do_req(1'b1, 32'h101, 2'b00, 1'b0, 32'h00000080, 2);
    do_req(1'b0, 32'h101, 2'b00, 1'b0, 32'h0, 3);
    chk("lb_lit", last_rdata, 32'hFFFFFF80);

    wr_log.delete();
    do_req(1'b1, 32'h103, 2'b10, 1'b0, 32'hAABBCCDD, 3);
    chk("xsw_cnt", 32'(wr_log.size()), 32'h2);
    chk("xsw_a0", 32'(wr_log[0].addr), 32'd64);
    chk("xsw_be0", 32'(wr_log[0].be), 32'h8);
    chk("xsw_l3", 32'(wr_log[0].data[31:24]), 32'hDD);
    chk("xsw_a1", 32'(wr_log[1].addr), 32'd65);
    chk("xsw_be1", 32'(wr_log[1].be), 32'h7);
    chk("xsw_l02", 32'(wr_log[1].data[23:0]), 32'hAABBCC);
    rd_log.delete();
    do_req(1'b0, 32'h103, 2'b10, 1'b0, 32'h0, 5);
    chk("xlw_lit", last_rdata, 32'hAABBCCDD);
    chk("xlw_reads", 32'(rd_log.size()), 32'h2);

    do_req(1'b1, 32'h0FF, 2'b00, 1'b0, 32'h00, 2);
    do_req(1'b1, 32'h100, 2'b00, 1'b0, 32'h80, 2);
    do_req(1'b0, 32'h0FF, 2'b01, 1'b0, 32'h0, 5);
    chk("lh_lit", last_rdata, 32'hFFFF8000);
    do_req(1'b0, 32'h0FF, 2'b01, 1'b1, 32'h0, 5);
    chk("lhu_lit", last_rdata, 32'h00008000);

    do_req(1'b1, 32'hFFE, 2'b01, 1'b0, 32'h0000BEEF, 2);
    do_req(1'b1, 32'h000, 2'b01, 1'b0, 32'h0000CAFE, 2);
    rd_log.delete();
    do_req(1'b0, 32'hFFE, 2'b10, 1'b0, 32'h0, 5);
    chk("wrap_lit", last_rdata, 32'hCAFEBEEF);
    chk("wrap_rd0", 32'(rd_log[0]), 32'd1023);
    chk("wrap_rd1", 32'(rd_log[1]), 32'd0);

    wr_log.delete();
    do_req(1'b1, 32'h204, 2'b11, 1'b1, 32'h5A6B7C8D, 2);
    chk("sz3_be", 32'(wr_log[0].be), 32'hF);
    do_req(1'b0, 32'h204, 2'b11, 1'b0, 32'h0, 3);
    chk("sz3_lit", last_rdata, 32'h5A6B7C8D);

    // Reset while the second half of a crossing load is outstanding.
    start = resp_cnt;
    launch(1'b0, 32'h103, 2'b10, 1'b0, 32'h0);
    g = 0;
    while (!(o_mem_rd_ready && o_mem_addr == 10'd65) && g < 50) begin
      @(negedge i_clk);
      g++;
    end
    chk("rd1_reached", 32'(o_mem_rd_ready && o_mem_addr == 10'd65), 32'h1);
    @(posedge i_clk);
    #1 i_rst = 1'b1;
    @(negedge i_clk);
    chk("ready_in_rst", 32'(o_req_ready), 32'h0);
    @(negedge i_clk);
    chk("strobes_after_rst",
        32'({o_resp_valid, o_mem_wr_valid, o_mem_rd_ready, o_mem_be, o_mem_addr}), 32'h0);
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    chk("ready_after_rst", 32'(o_req_ready), 32'h1);
    repeat (6) @(negedge i_clk);
    chk("no_resp_after_rst", 32'(resp_cnt), 32'(start));
    do_req(1'b0, 32'h103, 2'b10, 1'b0, 32'h0, 5);
    chk("post_rst_lit", last_rdata, 32'hAABBCCDD);

    stall = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 1) == 1) ? (32'h0F0 + 32'($urandom_range(0, 47))) : $urandom;
      do_req(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom, -1);
    end
    stall = 1'b0;
    repeat (4) @(negedge i_clk);

    mism = 0;
    for (int w = 0; w < 1024; w++)
      for (int b = 0; b < 4; b++)
        if (bram[w][8*b +: 8] !== ref_mem[4*w+b]) mism++;
    chk("bram_image", 32'(mism), 32'h0);
    chk("resp_queue_drained", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front end sitting directly upstream of the ready/valid BRAM wrapper (bram_rv).
- Accepts byte-addressed CPU requests (byte/half/word, signed/unsigned) and converts them into word-addressed BRAM transactions with byte enables.
- Splits misaligned accesses that cross a word boundary into two BRAM transactions.
- Merges, realigns and sign/zero-extends load data, then returns a single response.

Parameters:
DATA_WIDTH, 32, BRAM word width; only 32 supported.
ADDR_WIDTH, 10, BRAM word-address width.

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_req_valid  in  1  CPU request valid
o_req_ready  out  1  unit can accept a request
i_req_write  in  1  1 = store, 0 = load
i_req_addr  in  32  byte address; bits above ADDR_WIDTH+1 ignored
i_req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = treated as word
i_req_unsigned  in  1  zero-extend load (LBU/LHU); ignored for word
i_req_wdata  in  32  store data, right-justified
o_resp_valid  out  1  one-cycle completion pulse for loads and stores
o_resp_rdata  out  32  extended load data; 0 for stores
o_mem_addr  out  ADDR_WIDTH  BRAM word address
o_mem_wdata  out  32  lane-aligned store data
o_mem_be  out  4  byte write enables
o_mem_wr_valid  out  1  BRAM write strobe
i_mem_wr_ready  in  1  BRAM write accepted
o_mem_rd_ready  out  1  BRAM read request
i_mem_rd_valid  in  1  BRAM read data valid
i_mem_rdata  in  32  BRAM read data

Behaviour:
- Clock is i_clk. Reset is i_rst: synchronous, active-high.
- FSM states: IDLE, WR0, WR1, RD0, RD1, RESP.
- o_req_ready = (state == IDLE) && !i_rst.
- Handshake in IDLE (valid && ready): latch all request fields. Go to WR0 if write, else RD0.
- Derived values, registered at accept:
  - off = addr[1:0]; n = 1/2/4 bytes.
  - mask = 0001 / 0011 / 1111.
  - idx0 = addr[ADDR_WIDTH+1:2]; idx1 = idx0 + 1, wrapping mod 2^ADDR_WIDTH.
  - cross = (off + n > 4).
- Lane mapping is little-endian: request byte k goes to lane (off+k) mod 4 of word idx0 + (off+k)/4.
- Store:
  - o_mem_wdata = wdata rotated left by 8*off; same value in both transactions.
  - WR0: addr = idx0, be = (mask << off)[3:0], wr_valid = 1. Hold until i_mem_wr_ready. Then go to WR1 if cross, else RESP.
  - WR1: addr = idx1, be = (mask << off)[7:4], same handshake, then RESP.
- Load:
  - RD0: addr = idx0, rd_ready = 1; addr held stable until i_mem_rd_valid. On valid, capture word0, drop rd_ready, go to RD1 if cross, else RESP.
  - RD1: same sequence with idx1, capturing word1, then RESP.
  - Result = {word1, word0} >> 8*off, truncated to n bytes. Sign-extend if !unsigned and size < word; otherwise zero-extend.
- RESP: o_resp_valid = 1 for exactly one cycle, o_resp_rdata valid that cycle. Next state IDLE.
- Outside active states all mem outputs are 0. o_resp_rdata is 0 except in RESP.
- Latency with the bram_rv timing (read data one cycle after rd_ready, write accepted same cycle), request accepted at edge T:
  - aligned store: resp at T+2; crossing store: T+3.
  - aligned load: resp at T+3; crossing load: T+5.
- No new request is accepted until RESP completes (back-to-back accept only from IDLE).
- Reset, including mid-operation: state goes to IDLE next edge. All outputs 0 except o_req_ready (1 after reset deasserts). No pending response is issued. A half-completed crossing store is not rolled back.
- i_req_size = 11 behaves exactly as 10.

Test Plan:
- Store word 0x11223344 to 0x100, then load word from 0x100 → one write (addr 64, be 1111); resp 0x11223344; store resp at T+2, load resp at T+3.
- Store byte 0x31 to 0x102 → be 0100, wdata[23:16] = 0x31. Load byte unsigned from 0x102 → 0x00000031. Store byte 0x80 to 0x101, then load byte signed from 0x101 → 0xFFFFFF80.
- Store word 0xAABBCCDD to 0x103 → write word 64 be 1000 (lane3 = DD), then word 65 be 0111 (lanes 0–2 = CC, BB, AA). Load word from 0x103 → two reads, resp 0xAABBCCDD at T+5.
- Memory byte 0xFF = 0x00, byte 0x100 = 0x80. Load half signed from 0x0FF → 0xFFFF8000; load half unsigned from 0x0FF → 0x00008000.
- Wrap-around with ADDR_WIDTH = 10: load word from byte 0xFFE → reads word 1023 then word 0; result assembled from lanes 2–3 of word 1023 and lanes 0–1 of word 0.
- Reset asserted during RD1 → no o_resp_valid. All mem strobes 0 on the next cycle. o_req_ready 1 the cycle after reset deasserts. Next request completes normally.
